// File: rtl/bcd_addsub_serial.sv
// Digit-serial signed (sign-magnitude) BCD adder/subtractor.
// One shared digit slice processes one BCD digit per clock, LSD first.
module bcd_addsub_serial #(
  parameter int unsigned NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic              SUB,
  input  logic              A_SIGN,
  input  logic [4*NDIG-1:0] A_MAG,
  input  logic              B_SIGN,
  input  logic [4*NDIG-1:0] B_MAG,
  output logic              R_SIGN,
  output logic [4*NDIG-1:0] R_MAG,
  output logic              OVF,
  output logic              ERR,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned W  = 4 * NDIG;
  localparam int unsigned CW = $clog2(NDIG) + 1;
  localparam logic [CW-1:0] LastIdx = CW'(NDIG - 1);
  localparam logic [CW-1:0] IdxOne  = 1;

  typedef enum logic [1:0] {StIdle, StAdd, StFix, StFin} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           a_sign_q, a_sign_d;
  logic           diff_q, diff_d;
  logic           carry_q, carry_d;
  logic           r_sign_q, r_sign_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [3:0]     dig_x, dig_y, dig_out;
  logic [4:0]     dig_sum, dig_adj;
  logic           dig_cout;
  logic           bad_digit;
  logic [W+3:0]   r_shift;

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (A_MAG[4*i +: 4] > 4'd9 || B_MAG[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared digit slice: ADD feeds a/b (b 9's-complemented on the difference path),
  // FIX feeds the 9's complement of the stored result digit.
  always_comb begin
    dig_x = a_q[3:0];
    dig_y = diff_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    if (state_q == StFix) begin
      dig_x = 4'd9 - r_q[3:0];
      dig_y = 4'd0;
    end
    dig_sum = {1'b0, dig_x} + {1'b0, dig_y} + {4'b0000, carry_q};
    dig_adj = dig_sum + 5'd6;
    if (dig_sum > 5'd9) begin
      dig_out  = dig_adj[3:0];
      dig_cout = 1'b1;
    end else begin
      dig_out  = dig_sum[3:0];
      dig_cout = 1'b0;
    end
    // Result register rotates right; the new digit enters at the top.
    r_shift = {dig_out, r_q};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    idx_d    = idx_q;
    a_sign_d = a_sign_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    r_sign_d = r_sign_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (START && !done_q) begin
          busy_d   = 1'b1;
          r_d      = '0;
          r_sign_d = 1'b0;
          ovf_d    = 1'b0;
          a_d      = A_MAG;
          b_d      = B_MAG;
          a_sign_d = A_SIGN;
          diff_d   = A_SIGN ^ B_SIGN ^ SUB;
          carry_d  = A_SIGN ^ B_SIGN ^ SUB;
          idx_d    = '0;
          if (bad_digit) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            err_d   = 1'b0;
            state_d = StAdd;
          end
        end
      end

      StAdd: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        r_d     = r_shift[W+3:4];
        carry_d = dig_cout;
        idx_d   = idx_q + IdxOne;
        if (idx_q == LastIdx) begin
          idx_d = '0;
          if (!diff_q) begin
            ovf_d    = dig_cout;
            r_sign_d = a_sign_q;
            state_d  = StFin;
          end else if (dig_cout) begin
            r_sign_d = a_sign_q;
            state_d  = StFin;
          end else begin
            // |B| > |A|: result is in 10's complement form, recomplement it.
            r_sign_d = ~a_sign_q;
            carry_d  = 1'b1;
            state_d  = StFix;
          end
        end
      end

      StFix: begin
        r_d     = r_shift[W+3:4];
        carry_d = dig_cout;
        idx_d   = idx_q + IdxOne;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StFin;
        end
      end

      StFin: begin
        if (!ovf_q && r_q == '0) r_sign_d = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      a_sign_q <= 1'b0;
      diff_q   <= 1'b0;
      carry_q  <= 1'b0;
      r_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      a_sign_q <= a_sign_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      r_sign_q <= r_sign_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign R_SIGN = r_sign_q;
  assign R_MAG  = r_q;
  assign OVF    = ovf_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule
